md_sequencer: RTL and testbench

//  Sequences the shared multiply/divide unit and owns the HI/LO registers.

---
 rtl/md_sequencer_pkg.sv | 35 +++
 rtl/md_sequencer_arith.sv | 58 +++++
 rtl/md_sequencer.sv | 139 +++++++++++++
 tb/tb_md_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg
// Shared encodings for the multiply/divide sequencer and the E-stage decoder:
// operation codes, mthi/mtlo write codes, HI/LO read selects, default cycle
// counts and the sequencer state type.
package md_sequencer_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    localparam logic [1:0] MD_WE_HI  = 2'd1;
    localparam logic [1:0] MD_WE_LO  = 2'd2;
    localparam logic [1:0] MD_SEL_HI = 2'd1;
    localparam logic [1:0] MD_SEL_LO = 2'd2;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

    // Busy-cycle countdown width.
    localparam int unsigned MD_CNT_W = 16;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } md_state_e;

    // Divide ops share op[1]=1.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/md_sequencer_arith.sv
// md_sequencer_arith
// Combinational multiply/divide datapath.
// Ports:
//   i_op      operation (md_op_e encoding)
//   i_a       operand A / dividend
//   i_b       operand B / divisor
//   o_result  {HI, LO}: product, or {remainder, quotient}
//   o_div0    divisor is zero (divide ops leave HI/LO unchanged)
module md_sequencer_arith
    import md_sequencer_pkg::*;
(
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_result,
    output logic        o_div0
);

    logic               w_ovf;
    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic signed [31:0] w_sa;
    logic signed [31:0] w_sb;
    logic signed [31:0] w_sq;
    logic signed [31:0] w_sr;
    logic [31:0]        w_ub;
    logic [31:0]        w_uq;
    logic [31:0]        w_ur;

    assign o_div0 = (i_b == 32'd0);
    assign w_ovf  = (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    assign w_smul = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_umul = {32'd0, i_a} * {32'd0, i_b};

    // Divisor forced to 1 for /0 and for 0x80000000/-1: /0 discards the result anyway,
    // and x/1 yields exactly the required 0x80000000 quotient with zero remainder.
    assign w_sa = $signed(i_a);
    assign w_sb = (o_div0 || w_ovf) ? 32'sd1 : $signed(i_b);
    assign w_sq = w_sa / w_sb;
    assign w_sr = w_sa % w_sb;

    assign w_ub = o_div0 ? 32'd1 : i_b;
    assign w_uq = i_a / w_ub;
    assign w_ur = i_a % w_ub;

    always_comb begin
        o_result = 64'd0;
        case (i_op)
            MD_MULT:  o_result = w_smul;
            MD_MULTU: o_result = w_umul;
            MD_DIV:   o_result = {w_sr, w_sq};
            MD_DIVU:  o_result = {w_ur, w_uq};
            default:  o_result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_sequencer.sv
// md_sequencer
// Sequences the shared multiply/divide unit and owns HI/LO. The result is
// computed at start, held while a countdown models the unit latency, and
// committed to HI/LO on the terminal-count edge.
// Configuration macro: MD_CANCEL_EN -- when defined, i_cancel suppresses a
// start or mthi/mtlo write in the same cycle; otherwise i_cancel is ignored.
// Ports:
//   i_clk, i_reset       clock / async active-high reset
//   i_start, i_op        issue strobe and operation
//   i_rs_val, i_rt_val   operands (latched at start)
//   i_we, i_wdata        mthi (1) / mtlo (2) write
//   i_rd_sel             read select: 1 HI, 2 LO, else 0
//   i_d_md_use           D-stage instruction uses the MD unit
//   i_cancel             E-stage flush
//   o_rdata              combinational HI/LO/0
//   o_busy               operation in flight
//   o_stall_req          D-stage stall request
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs_val,
    input  logic [31:0] i_rt_val,
    input  logic [1:0]  i_we,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_rd_sel,
    input  logic        i_d_md_use,
    input  logic        i_cancel,
    output logic [31:0] o_rdata,
    output logic        o_busy,
    output logic        o_stall_req
);

    localparam logic [MD_CNT_W-1:0] MULT_N = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_N  = MD_CNT_W'(DIV_CYCLES);

    md_state_e           r_state;
    logic [MD_CNT_W-1:0] r_cnt;
    logic                r_busy;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;
    logic [63:0]         r_res;
    logic                r_div0;

    logic [63:0]         w_res;
    logic                w_div0;
    logic                w_cancel;
    logic                w_start_ok;
    logic                w_we_ok;
    logic [MD_CNT_W-1:0] w_n;

`ifdef MD_CANCEL_EN
    assign w_cancel = i_cancel;
`else
    logic w_unused_cancel;
    assign w_unused_cancel = i_cancel;
    assign w_cancel        = 1'b0;
`endif

    md_sequencer_arith u_arith (
        .i_op     (i_op),
        .i_a      (i_rs_val),
        .i_b      (i_rt_val),
        .o_result (w_res),
        .o_div0   (w_div0)
    );

    assign w_n        = md_is_div(i_op) ? DIV_N : MULT_N;
    assign w_start_ok = i_start && (r_state == ST_IDLE) && !w_cancel;
    // Start wins over a same-cycle write; writes are dropped while busy.
    assign w_we_ok    = !i_start && (r_state == ST_IDLE) && !w_cancel;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_res   <= 64'd0;
            r_div0  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= w_n;
                        r_res   <= w_res;
                        r_div0  <= w_div0;
                    end else if (w_we_ok) begin
                        if (i_we == MD_WE_HI) begin
                            r_hi <= i_wdata;
                        end else if (i_we == MD_WE_LO) begin
                            r_lo <= i_wdata;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_cnt == MD_CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        if (!r_div0) begin
                            r_hi <= r_res[63:32];
                            r_lo <= r_res[31:0];
                        end
                    end else begin
                        r_cnt <= r_cnt - MD_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        o_rdata = 32'd0;
        if (i_rd_sel == MD_SEL_HI) begin
            o_rdata = r_hi;
        end else if (i_rd_sel == MD_SEL_LO) begin
            o_rdata = r_lo;
        end
    end

    assign o_busy      = r_busy;
    assign o_stall_req = i_d_md_use && (i_start || r_busy);

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer
// Directed self-checking bench for md_sequencer (MULT_CYCLES=5, DIV_CYCLES=10).
module tb_md_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [1:0]  we;
    logic [31:0] wdata;
    logic [1:0]  rd_sel;
    logic        d_md_use;
    logic        cancel;
    logic [31:0] rdata;
    logic        busy;
    logic        stall_req;

    int checks;
    int failures;

    md_sequencer #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_start     (start),
        .i_op        (op),
        .i_rs_val    (rs_val),
        .i_rt_val    (rt_val),
        .i_we        (we),
        .i_wdata     (wdata),
        .i_rd_sel    (rd_sel),
        .i_d_md_use  (d_md_use),
        .i_cancel    (cancel),
        .o_rdata     (rdata),
        .o_busy      (busy),
        .o_stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        tick();
        start = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] w, input logic [31:0] d);
        we = w; wdata = d;
        tick();
        we = 2'd0;
    endtask

    // Counts busy cycles from the current one until idle, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_hi got=%h exp=%h", rdata, 32'd0); end
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_lo got=%h exp=%h", rdata, 32'd0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (stall_req !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_req); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mthi_mtlo();
        do_write(2'd1, 32'h11);
        do_write(2'd2, 32'h22);
        do_write(2'd3, 32'hDEAD);
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'h11) begin failures++; $display("FAIL mthi got=%h exp=%h", rdata, 32'h11); end
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'h22) begin failures++; $display("FAIL mtlo got=%h exp=%h", rdata, 32'h22); end
        rd_sel = 2'd0; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rdsel0 got=%h exp=0", rdata); end
        rd_sel = 2'd3; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rdsel3 got=%h exp=0", rdata); end
        tick();
    endtask

    task automatic test_mult();
        int n;
        do_start(2'd0, 32'hFFFF_FFFF, 32'd2);
        // Operands must have been latched at start.
        rs_val = 32'd0; rt_val = 32'd0;
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'h22) begin failures++; $display("FAIL mult_no_fwd got=%h exp=%h", rdata, 32'h22); end
        wait_idle(n);
        checks++; if (n !== 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", n); end
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got=%h exp=%h", rdata, 32'hFFFF_FFFF); end
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mult_lo got=%h exp=%h", rdata, 32'hFFFF_FFFE); end
        tick();
    endtask

    task automatic test_multu();
        int n;
        do_start(2'd1, 32'hFFFF_FFFF, 32'd2);
        wait_idle(n);
        checks++; if (n !== 5) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=5", n); end
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL multu_hi got=%h exp=%h", rdata, 32'h1); end
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_lo got=%h exp=%h", rdata, 32'hFFFF_FFFE); end
        tick();
    endtask

    task automatic test_div();
        int n;
        do_start(2'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL div_busy_cycles got=%0d exp=10", n); end
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got=%h exp=%h", rdata, 32'hFFFF_FFFD); end
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got=%h exp=%h", rdata, 32'hFFFF_FFFF); end
        tick();
        // Unsigned view of the same operands: 0xFFFFFFF9 / 2 = 0x7FFFFFFC rem 1.
        do_start(2'd3, 32'hFFFF_FFF9, 32'd2);
        wait_idle(n);
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'h7FFF_FFFC) begin failures++; $display("FAIL divu_lo got=%h exp=%h", rdata, 32'h7FFF_FFFC); end
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL divu_hi got=%h exp=%h", rdata, 32'h1); end
        tick();
    endtask

    task automatic test_div_overflow();
        int n;
        do_start(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(n);
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'h8000_0000) begin failures++; $display("FAIL divovf_lo got=%h exp=%h", rdata, 32'h8000_0000); end
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL divovf_hi got=%h exp=0", rdata); end
        tick();
    endtask

    task automatic test_div_zero();
        int n;
        do_write(2'd1, 32'h11);
        do_write(2'd2, 32'h22);
        do_start(2'd3, 32'd7, 32'd0);
        wait_idle(n);
        checks++; if (n !== 10) begin failures++; $display("FAIL div0_busy_cycles got=%0d exp=10", n); end
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'h11) begin failures++; $display("FAIL div0_hi got=%h exp=%h", rdata, 32'h11); end
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'h22) begin failures++; $display("FAIL div0_lo got=%h exp=%h", rdata, 32'h22); end
        tick();
    endtask

    task automatic test_stall();
        int n;
        d_md_use = 1'b1;
        start = 1'b1; op = 2'd0; rs_val = 32'd3; rt_val = 32'd3;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (!stall_req) break;
            n++;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        checks++; if (n !== 6) begin failures++; $display("FAIL stall_cycles got=%0d exp=6", n); end
        d_md_use = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_end_busy got=%b exp=0", busy); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        do_write(2'd1, 32'd0);
        do_start(2'd1, 32'd3, 32'd4);
        // Start and write while busy: both ignored.
        start = 1'b1; op = 2'd3; rs_val = 32'd100; rt_val = 32'd5;
        tick();
        start = 1'b0;
        do_write(2'd1, 32'hAA);
        wait_idle(n);
        checks++; if (n !== 3) begin failures++; $display("FAIL b2b_busy_rest got=%0d exp=3", n); end
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL b2b_hi got=%h exp=0", rdata); end
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'd12) begin failures++; $display("FAIL b2b_lo got=%h exp=%h", rdata, 32'd12); end
        tick();
        // Start and mtlo in the same cycle: start wins.
        we = 2'd2; wdata = 32'h99;
        do_start(2'd0, 32'd2, 32'd3);
        we = 2'd0;
        wait_idle(n);
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'd6) begin failures++; $display("FAIL start_we_lo got=%h exp=%h", rdata, 32'd6); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_write(2'd1, 32'h55);
        do_start(2'd2, 32'd100, 32'd7);
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", rdata); end
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", rdata); end
        tick();
        rst = 1'b0;
        tick();
        tick();
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL rstmid_no_commit got=%h exp=0", rdata); end
        tick();
    endtask

    task automatic test_cancel();
        int n;
        cancel = 1'b1;
`ifdef MD_CANCEL_EN
        do_start(2'd0, 32'd5, 32'd5);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cancel_start busy=%b exp=0", busy); end
        do_write(2'd1, 32'h77);
        cancel = 1'b0;
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL cancel_we got=%h exp=0", rdata); end
`else
        do_start(2'd0, 32'd5, 32'd5);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL nocancel_start busy=%b exp=1", busy); end
        wait_idle(n);
        do_write(2'd1, 32'h77);
        cancel = 1'b0;
        rd_sel = 2'd2; #1;
        checks++; if (rdata !== 32'd25) begin failures++; $display("FAIL nocancel_lo got=%h exp=%h", rdata, 32'd25); end
        rd_sel = 2'd1; #1;
        checks++; if (rdata !== 32'h77) begin failures++; $display("FAIL nocancel_we got=%h exp=%h", rdata, 32'h77); end
`endif
        cancel = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b0; start = 1'b0; op = 2'd0; rs_val = 32'd0; rt_val = 32'd0;
        we = 2'd0; wdata = 32'd0; rd_sel = 2'd0; d_md_use = 1'b0; cancel = 1'b0;
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_multu();
        test_div();
        test_div_overflow();
        test_div_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_cancel();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
